// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if
//   Request/response bus between the core memory stage and the data memory.
//   master : core side. It drives the request fields and rsp_ready.
//   slave  : memory side. It drives req_ready and the response fields.
//   req_valid/req_ready : request handshake
//   req_we, req_fun3, req_addr, req_wdata : request fields
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata, rsp_err : response fields
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_fun3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_fun3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_fun3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Data memory for the RV32I load/store path. It takes one request at a time.
//   Stores are byte, half or word writes with lane masking. Loads are byte, half
//   or word reads with sign or zero extension. Each request gets exactly one
//   response on a valid/ready handshake.
// Parameters
//   DEPTH   : number of 32-bit words. The word index is addr[31:2].
//   LATENCY : wait cycles between accept and commit (0..15).
// Ports
//   clk : clock, rising edge
//   rst : asynchronous reset, active high
//   bus : data_mem_responder_if.slave, carrying the request and response handshakes
//
// state | meaning
// IDLE  | ready for a request (req_ready=1 when rst=0)
// WAIT  | request captured; counting LATENCY cycles
// RESP  | memory committed; response held until rsp_ready
module data_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input logic                  clk,
  input logic                  rst,
  data_mem_responder_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit HAS_WAIT = (LATENCY > 0);
  localparam logic [3:0] CNT_LAST = HAS_WAIT ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  fun3_q, fun3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  // Contents are not reset.
  logic [31:0] mem_array [DEPTH];

  logic        accept;
  logic        commit;
  logic        c_we;
  logic [2:0]  c_fun3;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [IDX_W-1:0] c_idx;
  logic        c_misalign;
  logic        c_illegal;
  logic        c_range;
  logic        c_err;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_data;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        mem_we;

  assign bus.req_ready = (state_q == ST_IDLE) & ~rst;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  assign accept = bus.req_valid & bus.req_ready;

  // With LATENCY=0 the commit happens on the accept edge. The captured copy
  // does not exist yet on that edge, so the live bus fields are used while idle.
  always_comb begin
    if (state_q == ST_IDLE) begin
      c_we    = bus.req_we;
      c_fun3  = bus.req_fun3;
      c_addr  = bus.req_addr;
      c_wdata = bus.req_wdata;
    end else begin
      c_we    = we_q;
      c_fun3  = fun3_q;
      c_addr  = addr_q;
      c_wdata = wdata_q;
    end
  end

  assign c_idx = c_addr[IDX_W+1:2];

  always_comb begin
    c_misalign = 1'b0;
    c_illegal  = 1'b0;
    case (c_fun3)
      3'b001, 3'b101: c_misalign = c_addr[0];
      3'b010:         c_misalign = (c_addr[1:0] != 2'b00);
      default:        c_misalign = 1'b0;
    endcase
    if (c_we) begin
      c_illegal = !((c_fun3 == 3'b000) || (c_fun3 == 3'b001) || (c_fun3 == 3'b010));
    end else begin
      c_illegal = (c_fun3 == 3'b011) || (c_fun3 == 3'b110) || (c_fun3 == 3'b111);
    end
    c_range = (c_addr[31:2] >= 30'(DEPTH));
    c_err   = c_misalign | c_illegal | c_range;
  end

  // Load path: select the lane little-endian, then extend it.
  always_comb begin
    rd_word = mem_array[c_idx];
    rd_byte = 8'h00;
    case (c_addr[1:0])
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = c_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (c_fun3)
      3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
      3'b010:  ld_data = rd_word;
      3'b100:  ld_data = {24'h0, rd_byte};
      3'b101:  ld_data = {16'h0, rd_half};
      default: ld_data = 32'h0;
    endcase
  end

  // Store path: the store data is replicated across lanes, so the byte
  // enables alone pick which bytes change.
  always_comb begin
    wr_be   = 4'b0000;
    wr_data = c_wdata;
    case (c_fun3)
      3'b000: begin
        wr_be   = 4'b0001 << c_addr[1:0];
        wr_data = {4{c_wdata[7:0]}};
      end
      3'b001: begin
        wr_be   = c_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{c_wdata[15:0]}};
      end
      3'b010: begin
        wr_be   = 4'b1111;
        wr_data = c_wdata;
      end
      default: begin
        wr_be   = 4'b0000;
        wr_data = c_wdata;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    fun3_d      = fun3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    commit      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d    = bus.req_we;
          fun3_d  = bus.req_fun3;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = 4'd0;
          if (HAS_WAIT) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (commit) begin
      rsp_err_d   = c_err;
      rsp_rdata_d = (c_err || c_we) ? 32'h0 : ld_data;
    end
  end

  assign mem_we = commit & c_we & ~c_err & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      fun3_q      <= 3'd0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      fun3_q      <= fun3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) begin
          mem_array[c_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if if_a ();
  data_mem_responder_if if_b ();

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .bus(if_a)
  );
  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(if_b)
  );

  // sel=0 drives u_dut (LATENCY=2), sel=1 drives u_dut0 (LATENCY=0).
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_fun3 = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_ready = 1'b0;

  assign if_a.req_valid = req_valid & ~sel;
  assign if_b.req_valid = req_valid & sel;
  assign if_a.rsp_ready = rsp_ready & ~sel;
  assign if_b.rsp_ready = rsp_ready & sel;
  assign if_a.req_we    = req_we;
  assign if_b.req_we    = req_we;
  assign if_a.req_fun3  = req_fun3;
  assign if_b.req_fun3  = req_fun3;
  assign if_a.req_addr  = req_addr;
  assign if_b.req_addr  = req_addr;
  assign if_a.req_wdata = req_wdata;
  assign if_b.req_wdata = req_wdata;

  logic        s_req_ready, s_rsp_valid, s_rsp_err;
  logic [31:0] s_rsp_rdata;
  assign s_req_ready = sel ? if_b.req_ready : if_a.req_ready;
  assign s_rsp_valid = sel ? if_b.rsp_valid : if_a.rsp_valid;
  assign s_rsp_err   = sel ? if_b.rsp_err   : if_a.rsp_err;
  assign s_rsp_rdata = sel ? if_b.rsp_rdata : if_a.rsp_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte-addressed reference memory for u_dut.
  logic [7:0] mm [DEPTH*4];

  task automatic model(input bit we, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output bit er);
    bit mis, ill, oor;
    logic [7:0] b0, b1;
    mis = ((f == 3'd1 || f == 3'd5) && a[0]) || (f == 3'd2 && a[1:0] != 2'd0);
    if (we) ill = !(f == 3'd0 || f == 3'd1 || f == 3'd2);
    else    ill = (f == 3'd3 || f == 3'd6 || f == 3'd7);
    oor = (a / 4) >= DEPTH;
    er  = mis | ill | oor;
    rd  = 32'h0;
    if (!er) begin
      if (we) begin
        mm[a] = wd[7:0];
        if (f != 3'd0) mm[a+1] = wd[15:8];
        if (f == 3'd2) begin
          mm[a+2] = wd[23:16];
          mm[a+3] = wd[31:24];
        end
      end else begin
        b0 = mm[a];
        case (f)
          3'd0: rd = (b0 >= 8'h80) ? 32'hFFFFFF00 + 32'(b0) : 32'(b0);
          3'd4: rd = 32'(b0);
          3'd1, 3'd5: begin
            b1 = mm[a+1];
            rd = 32'(b1) * 256 + 32'(b0);
            if (f == 3'd1 && b1 >= 8'h80) rd = rd + 32'hFFFF0000;
          end
          default: rd = {mm[a+3], mm[a+2], mm[a+1], mm[a]};
        endcase
      end
    end
  endtask

  task automatic do_txn(input bit s, input bit we, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] wd, input int hold,
                        input logic [31:0] exp_rd,
                        output logic [31:0] rd, output bit er, output int lat);
    int n;
    @(negedge clk);
    sel = s; req_we = we; req_fun3 = f; req_addr = a; req_wdata = wd;
    req_valid = 1'b1; rsp_ready = 1'b0;
    n = 0;
    while (!s_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!s_req_ready) chk("req_ready_wait", 32'(s_req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_fun3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (!s_rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!s_rsp_valid) chk("rsp_timeout", 32'(s_rsp_valid), 32'd1);
    rd = s_rsp_rdata;
    er = s_rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(s_rsp_valid), 32'd1);
      chk("hold_rdata", s_rsp_rdata, exp_rd);
      chk("hold_req_ready", 32'(s_req_ready), 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    if (hold > 0) begin
      chk("hs_drop", 32'(s_rsp_valid), 32'd0);
      chk("next_ready", 32'(s_req_ready), 32'd1);
    end
  endtask

  logic [31:0] last_rd;
  bit          last_er;

  task automatic txn_chk(input string tag, input bit we, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] wd, input int hold);
    logic [31:0] erd, rd;
    bit eer, er;
    int lat;
    model(we, f, a, wd, erd, eer);
    do_txn(1'b0, we, f, a, wd, hold, erd, rd, er, lat);
    chk({tag, "_rdata"}, rd, erd);
    chk({tag, "_err"}, 32'(er), 32'(eer));
    chk({tag, "_lat"}, 32'(lat), 32'(LAT + 1));
    last_rd = rd;
    last_er = er;
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd0;
    bit er0;
    int lat0;
    logic [2:0] f;
    logic [31:0] a;
    bit we;

    #1 rst = 1'b1;
    #2;
    chk("rst_req_ready", 32'(if_a.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(if_a.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", if_a.rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(if_a.rsp_err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_req_ready", 32'(if_a.req_ready), 32'd1);

    for (int w = 0; w < 8; w++) txn_chk("init", 1'b1, 3'd2, 32'h100 + 32'(4*w), $urandom, 0);
    txn_chk("init200", 1'b1, 3'd2, 32'h200, 32'h0, 0);

    txn_chk("t1_sw", 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 0);
    txn_chk("t1_lw", 1'b0, 3'd2, 32'h100, 32'h0, 0);
    chk("t1_lw_const", last_rd, 32'hDEADBEEF);

    txn_chk("t2_sb", 1'b1, 3'd0, 32'h101, 32'h5A5A5A80, 0);
    txn_chk("t2_lb", 1'b0, 3'd0, 32'h101, 32'h0, 0);
    chk("t2_lb_const", last_rd, 32'hFFFFFF80);
    txn_chk("t2_lbu", 1'b0, 3'd4, 32'h101, 32'h0, 0);
    chk("t2_lbu_const", last_rd, 32'h00000080);
    txn_chk("t2_lw", 1'b0, 3'd2, 32'h100, 32'h0, 0);
    chk("t2_lw_const", last_rd, 32'hDEAD80EF);

    txn_chk("t3_sw", 1'b1, 3'd2, 32'h100, 32'h80011234, 0);
    txn_chk("t3_lh", 1'b0, 3'd1, 32'h102, 32'h0, 0);
    chk("t3_lh_const", last_rd, 32'hFFFF8001);
    txn_chk("t3_lhu", 1'b0, 3'd5, 32'h102, 32'h0, 0);
    chk("t3_lhu_const", last_rd, 32'h00008001);

    txn_chk("t4_sw_mis", 1'b1, 3'd2, 32'h102, 32'h12345678, 0);
    chk("t4_sw_mis_const", 32'(last_er), 32'd1);
    txn_chk("t4_lw", 1'b0, 3'd2, 32'h100, 32'h0, 0);
    chk("t4_lw_const", last_rd, 32'h80011234);
    txn_chk("t4_oor", 1'b0, 3'd2, 32'(4*DEPTH), 32'h0, 0);
    chk("t4_oor_err", 32'(last_er), 32'd1);
    chk("t4_oor_rdata", last_rd, 32'h0);
    txn_chk("t4_f110", 1'b0, 3'd6, 32'h100, 32'h0, 0);
    chk("t4_f110_err", 32'(last_er), 32'd1);

    txn_chk("t5_hold", 1'b0, 3'd2, 32'h100, 32'h0, 5);

    // Reset while the store is waiting: it must never land.
    @(negedge clk);
    sel = 1'b0; req_we = 1'b1; req_fun3 = 3'd2; req_addr = 32'h200;
    req_wdata = 32'hA5A5A5A5; req_valid = 1'b1; rsp_ready = 1'b0;
    chk("t6_ready", 32'(s_req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("t6_in_wait", 32'(s_rsp_valid), 32'd0);
    rst = 1'b1;
    #1;
    chk("t6_rst_ready", 32'(s_req_ready), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("t6_no_rsp", 32'(s_rsp_valid), 32'd0);
    end
    txn_chk("t6_lw", 1'b0, 3'd2, 32'h200, 32'h0, 0);
    chk("t6_lw_const", last_rd, 32'h0);

    for (int i = 0; i < 80; i++) begin
      we = 1'($urandom);
      if ($urandom_range(0, 9) < 8) begin
        case ($urandom_range(0, 4))
          0: f = 3'd0;
          1: f = 3'd1;
          2: f = 3'd2;
          3: f = 3'd4;
          default: f = 3'd5;
        endcase
      end else begin
        f = 3'($urandom);
      end
      if ($urandom_range(0, 9) < 9) a = 32'h100 + 32'($urandom_range(0, 31));
      else a = 32'h00010000 | $urandom;
      txn_chk("rnd", we, f, a, $urandom, $urandom_range(0, 1));
    end

    do_txn(1'b1, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 32'h0, rd0, er0, lat0);
    chk("l0_sw_err", 32'(er0), 32'd0);
    chk("l0_sw_lat", 32'(lat0), 32'd1);
    do_txn(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 0, 32'hDEADBEEF, rd0, er0, lat0);
    chk("l0_lw_rdata", rd0, 32'hDEADBEEF);
    chk("l0_lw_err", 32'(er0), 32'd0);
    chk("l0_lw_lat", 32'(lat0), 32'd1);
    do_txn(1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 2, 32'hFFFFFFDE, rd0, er0, lat0);
    chk("l0_lb_rdata", rd0, 32'hFFFFFFDE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
